// File: rtl/mem_responder.sv
// Single-port word memory responder with request/response handshake.
// Optional wait states enabled by MEM_WAITSTATE_EN (uses LATENCY).
module mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IW = $clog2(DEPTH);
`ifdef MEM_WAITSTATE_EN
  localparam int EFF_LAT = LATENCY;
`else
  localparam int EFF_LAT = LATENCY * 0;
`endif
  localparam logic [3:0] CNT_INIT =
    (EFF_LAT > 0) ? 4'(EFF_LAT - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t            state;
  logic [3:0]        cnt;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;
  logic [3:0]        cap_be;

  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] a_word;
  logic [31:0]       a_wdata;
  logic [3:0]        a_be;
  logic [IW-1:0]     a_idx;
  logic              a_err;
  logic              accept;
  logic              go_resp;
  logic              mem_wr;
  logic [31:0]       rd_val;

  // With zero latency the access edge is the accept edge,
  // so the live request is used before it is captured.
  always_comb begin
    a_we    = cap_we;
    a_addr  = cap_addr;
    a_wdata = cap_wdata;
    a_be    = cap_be;
    if (state == IDLE) begin
      a_we    = req_we;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_be    = req_be;
    end
  end

  assign accept  = (state == IDLE) && req_valid && req_ready;
  assign go_resp = (accept && (EFF_LAT == 0)) ||
                   ((state == WAIT) && (cnt == 4'd0));
  assign a_word  = a_addr >> 2;
  assign a_err   = (a_addr[1:0] != 2'b00) ||
                   (a_word >= ADDR_W'(DEPTH));
  assign a_idx   = a_addr[2 +: IW];
  assign mem_wr  = rst_n && go_resp && a_we && !a_err;
  assign rd_val  = (a_err || a_we) ? 32'd0 : mem[a_idx];

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be[i]) begin
          mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= 32'd0;
      cap_be    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            req_ready <= 1'b0;
            if (EFF_LAT != 0) begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cnt       <= 4'd0;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
        end
      endcase
      if (go_resp) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_rdata <= rd_val;
        rsp_err   <= a_err;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder.
// Reference memory is a plain word array with byte-lane merge.
module tb_mem_responder;

  localparam int DEPTH = 1024;
`ifdef MEM_WAITSTATE_EN
  localparam int LAT     = 2;
  localparam int EXP_LAT = 2;
`else
  localparam int LAT     = 7;
  localparam int EXP_LAT = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  mem_responder #(
    .DEPTH(DEPTH),
    .ADDR_W(32),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_be(req_be),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] ref_mem [DEPTH];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic we,
                       input logic [31:0] addr,
                       input logic [31:0] wdata,
                       input logic [3:0] be,
                       output logic [31:0] rd,
                       output logic err);
    longint unsigned w;
    logic [31:0] old;
    w   = longint'(addr) / 4;
    err = (addr % 4 != 0) || (w >= DEPTH);
    rd  = 32'd0;
    if (!err) begin
      old = ref_mem[w];
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) old[8*i +: 8] = wdata[8*i +: 8];
        ref_mem[w] = old;
      end else begin
        rd = old;
      end
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic xact(input logic we,
                      input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input logic [3:0] be,
                      input string tag);
    logic [31:0] erd;
    logic eerr;
    int n;
    model(we, addr, wdata, be, erd, eerr);
    @(negedge clk);
    check({tag, ".ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    wait_rsp(n);
    check({tag, ".lat"}, n, EXP_LAT);
    check({tag, ".rdata"}, rsp_rdata, erd);
    check({tag, ".err"}, rsp_err, eerr);
    @(posedge clk); #1;
    check({tag, ".pulse"}, rsp_valid, 0);
    check({tag, ".hold"}, rsp_rdata, erd);
  endtask

  task automatic hold_test();
    logic [31:0] ea, eb;
    logic e;
    int n;
    model(1'b0, 32'h10, 32'd0, 4'd0, ea, e);
    model(1'b0, 32'h20, 32'd0, 4'd0, eb, e);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_be    = 4'hF;
    @(posedge clk); #1;
    req_addr = 32'h20;
    wait_rsp(n);
    check("hold.lat_a", n, EXP_LAT);
    check("hold.busy", req_ready, 0);
    check("hold.rdata_a", rsp_rdata, ea);
    @(posedge clk); #1;
    check("hold.idle_ready", req_ready, 1);
    check("hold.no_early", rsp_valid, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(n);
    check("hold.lat_b", n, EXP_LAT);
    check("hold.rdata_b", rsp_rdata, eb);
    @(posedge clk); #1;
  endtask

  task automatic reset_test();
    logic [31:0] nd;
    logic seen;
    xact(1'b0, 32'h10, 32'd0, 4'hF, "rst.pre");
    nd = $urandom;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = nd;
    req_be    = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (EXP_LAT == 0) ref_mem[12] = nd;
    rst_n = 1'b0;
    #1;
    check("rst.ready", req_ready, 1);
    check("rst.valid", rsp_valid, 0);
    check("rst.rdata", rsp_rdata, 0);
    check("rst.err", rsp_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= rsp_valid;
    end
    check("rst.no_rsp", seen, 0);
    xact(1'b0, 32'h30, 32'd0, 4'hF, "rst.load");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.ready", req_ready, 1);
    check("reset.valid", rsp_valid, 0);
    check("reset.rdata", rsp_rdata, 0);
    check("reset.err", rsp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int w = 0; w < 64; w++)
      xact(1'b1, 32'(w * 4), $urandom, 4'hF, "init");

    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st10");
    xact(1'b0, 32'h10, 32'd0, 4'hF, "ld10");
    check("ld10.value", rsp_rdata, 32'hDEADBEEF);
    xact(1'b1, 32'h20, 32'h11223344, 4'hF, "st20");
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "st20be");
    xact(1'b0, 32'h20, 32'd0, 4'hF, "ld20");
    check("ld20.value", rsp_rdata, 32'h11BB33DD);
    xact(1'b1, 32'h20, 32'h55667788, 4'b0000, "st20none");
    xact(1'b0, 32'h20, 32'd0, 4'hF, "ld20b");
    xact(1'b0, 32'h22, 32'd0, 4'hF, "misal");
    xact(1'b0, 32'h1000, 32'd0, 4'hF, "oor_ld");
    xact(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, "oor_st");
    xact(1'b0, 32'h0, 32'd0, 4'hF, "ld0");

    hold_test();
    reset_test();

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)
        a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else if (r == 1)
        a = 32'((DEPTH + $urandom_range(0, 255)) * 4);
      else if (r == 2)
        a = 32'hFFFFFFFC;
      else
        a = 32'($urandom_range(0, 63) * 4);
      xact(1'($urandom), a, $urandom, 4'($urandom), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
